out_alu_control_unit: RTL and testbench
=======================================

// Module: out_alu_control_unit
// PURPOSE
//  Return-path control unit between the ALU and FIFO_OUT.
//  - Accepts finished results from the adder and the multiplier over independent valid/ready handshakes.
//  - Buffers one result per channel.
//  - Arbitrates round-robin when both channels hold a result.
//  - Packs each result as {result, id, op} and writes one entry per cycle into FIFO_OUT, obeying FIFO_OUT full.
//  - Keeps a count of written results for the CSR block.
// PARAMETERS
//  DATA_SIZE      16  result width (add result and 8x8 mul product are both DATA_SIZE bits)
//  ID_SIZE        8   transaction ID width
//  OPERATION_SIZE 2   op-code field width
//  CNT_WIDTH      16  width of written-results counter
//  FIFO_OUT_WIDTH DATA_SIZE+ID_SIZE+OPERATION_SIZE (26), derived, do not override
// PORTS
//  clk            in   1               clock, rising edge
//  rst_n          in   1               asynchronous reset, active low
//  a_res_valid    in   1               adder result valid
//  a_result       in   DATA_SIZE       adder result
//  a_res_id       in   ID_SIZE         adder result ID
//  a_res_ready    out  1               unit can accept an adder result
//  m_res_valid    in   1               multiplier result valid
//  m_result       in   DATA_SIZE       multiplier product
//  m_res_id       in   ID_SIZE         multiplier result ID
//  m_res_ready    out  1               unit can accept a multiplier result
//  full_out       in   1               FIFO_OUT full
//  w_en_out       out  1               FIFO_OUT write enable, one entry per high cycle
//  fifo_out_data  out  FIFO_OUT_WIDTH  FIFO_OUT write data
//  res_count      out  CNT_WIDTH       number of entries written, wraps
//  out_idle       out  1               both holding registers empty
// BEHAVIOUR
//  Reset values: hold valids 0, holds 0, last_grant=MUL, res_count 0.
//   After reset: a_res_ready=m_res_ready=1, w_en_out=0, fifo_out_data=0, out_idle=1.
//  Capture: transfer on clock edge when x_res_valid & x_res_ready.
//   Result and ID are latched into the channel hold register; hold valid is set.
//  x_res_ready = !x_hold_valid. Purely registered, so there is no path from full_out to ready.
//   Each channel therefore sustains one result per 2 cycles.
//  Write, combinational from registered state: w_en_out = (a_hold_valid | m_hold_valid) & !full_out.
//  Grant:
//   - Only one hold valid -> that channel.
//   - Both valid -> the channel != last_grant.
//   - last_grant updates only on an edge where w_en_out=1.
//  On an edge with w_en_out=1: the granted hold valid is cleared and res_count increments by 1,
//   wrapping 2^CNT_WIDTH-1 -> 0.
//  Entry layout: [1:0] op (ADD=2'b01, MUL=2'b10), [9:2] ID, [25:10] result.
//   When no hold is valid, fifo_out_data is 0.
//  Latency: result captured at edge N -> w_en_out high in cycle N..N+1 if not full and granted.
//   Entry is written at edge N+1.
//  full_out=1: no write. Holds, grant state and fifo_out_data are stable. Readies stay low for holding channels.
//  Simultaneous capture and drain on the same channel cannot occur, because ready=0 while hold is valid.
//   Capture on one channel while the other drains is allowed.
//  x_res_valid while x_res_ready=0: ignored. The ALU must hold its result.
//  Reset mid-operation: held results are discarded, counter cleared. No partial write is emitted.
// STRUCTURE
//  Shared package/header: OP_ADD, OP_MUL codes, entry field offsets (OP_LSB=0, ID_LSB=2, RES_LSB=10).
//   The input-side control unit uses the same codes and offsets.
//  Sub-module: result_hold_reg (valid flag + DATA_SIZE+ID_SIZE payload, load/clear), instantiated once per channel.
//   Built from d_ff_async_en.
//  Top: arbiter (last_grant flop), output mux and pack, res_count register.
// TESTING
//  1. Single add 0x1234 id 0x05:
//     - next cycle w_en_out=1, fifo_out_data={16'h1234,8'h05,2'b01};
//     - a_res_ready low exactly 1 cycle;
//     - res_count=1.
//  2. Same-cycle add 0x0011 id 0x01 and mul 0x00F0 id 0x02 after reset:
//     - ADD entry written first, MUL entry next cycle;
//     - out_idle=1 after.
//  3. Both holds full, full_out high 5 cycles:
//     - w_en_out=0, data stable, both readies 0;
//     - release -> 2 writes in round-robin order, then readies=1.
//  4. Adder presents valid every cycle with ids 1..6:
//     - accepted every 2nd cycle;
//     - FIFO entries carry ids 1..6 in order, none lost or duplicated.
//  5. rst_n asserted while mul hold valid and full_out=1:
//     - w_en_out=0, res_count=0, readies=1 after release;
//     - no stale entry written.
//  6. CNT_WIDTH=4, 17 writes -> res_count reads 1 (wrapped once).

Source files
------------

// File: rtl/out_alu_control_unit_pkg.sv
// Shared definitions for the ALU return path: op codes and FIFO entry field offsets.
// The input-side control unit packs and unpacks entries with the same values.
package out_alu_control_unit_pkg;

  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  localparam int unsigned OP_LSB  = 0;
  localparam int unsigned ID_LSB  = 2;
  localparam int unsigned RES_LSB = 10;

  // Channel that won the most recent write; used for round-robin between adder and multiplier.
  typedef enum logic {
    GRANT_ADD = 1'b0,
    GRANT_MUL = 1'b1
  } grant_t;

endpackage

// File: rtl/out_alu_control_unit_if.sv
// Result handshakes from the adder and multiplier plus the FIFO_OUT write port.
// slave: the return-path control unit; master: the ALU / FIFO_OUT side.
interface out_alu_control_unit_if #(
  parameter int unsigned DATA_SIZE      = 16,
  parameter int unsigned ID_SIZE        = 8,
  parameter int unsigned OPERATION_SIZE = 2
);
  localparam int unsigned FIFO_OUT_WIDTH = DATA_SIZE + ID_SIZE + OPERATION_SIZE;

  logic                      a_res_valid;
  logic [DATA_SIZE-1:0]      a_result;
  logic [ID_SIZE-1:0]        a_res_id;
  logic                      a_res_ready;

  logic                      m_res_valid;
  logic [DATA_SIZE-1:0]      m_result;
  logic [ID_SIZE-1:0]        m_res_id;
  logic                      m_res_ready;

  logic                      full_out;
  logic                      w_en_out;
  logic [FIFO_OUT_WIDTH-1:0] fifo_out_data;

  modport master (
    output a_res_valid, a_result, a_res_id,
    output m_res_valid, m_result, m_res_id,
    output full_out,
    input  a_res_ready, m_res_ready, w_en_out, fifo_out_data
  );

  modport slave (
    input  a_res_valid, a_result, a_res_id,
    input  m_res_valid, m_result, m_res_id,
    input  full_out,
    output a_res_ready, m_res_ready, w_en_out, fifo_out_data
  );
endinterface

// File: rtl/out_alu_control_unit_hold.sv
// Per-channel result holding register (valid flag + result/ID payload), built from enabled async-reset flops.

module d_ff_async_en #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // Load d when enabled; clear asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end
endmodule

module result_hold_reg #(
  parameter int unsigned PAYLOAD_W = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 clear,
  input  logic [PAYLOAD_W-1:0] d,
  output logic                 valid,
  output logic [PAYLOAD_W-1:0] q
);
  // Valid follows load when either load or clear fires; the two never coincide since load needs an empty hold.
  d_ff_async_en #(.WIDTH(1)) u_valid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load | clear),
    .d     (load),
    .q     (valid)
  );

  // Payload only changes on load; stale contents after a clear are masked by valid.
  d_ff_async_en #(.WIDTH(PAYLOAD_W)) u_payload (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load),
    .d     (d),
    .q     (q)
  );
endmodule

// File: rtl/out_alu_control_unit.sv
// Return-path control unit: buffers one adder and one multiplier result, arbitrates
// round-robin, packs {result, id, op} into FIFO_OUT and counts written entries.
module out_alu_control_unit
  import out_alu_control_unit_pkg::*;
#(
  parameter int unsigned DATA_SIZE      = 16,
  parameter int unsigned ID_SIZE        = 8,
  parameter int unsigned OPERATION_SIZE = 2,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  out_alu_control_unit_if.slave bus,
  output logic [CNT_WIDTH-1:0] res_count,
  output logic                 out_idle
);
  localparam int unsigned PAYLOAD_W      = DATA_SIZE + ID_SIZE;
  localparam int unsigned FIFO_OUT_WIDTH = DATA_SIZE + ID_SIZE + OPERATION_SIZE;

  logic                 a_hold_valid, m_hold_valid;
  logic [PAYLOAD_W-1:0] a_payload, m_payload;
  logic                 a_load, m_load, a_clear, m_clear;
  logic                 grant_mul, w_en;
  grant_t               last_grant;
  logic [FIFO_OUT_WIDTH-1:0] entry;

  // Ready depends only on the hold flags, so full_out never reaches the ALU side.
  assign bus.a_res_ready = !a_hold_valid;
  assign bus.m_res_ready = !m_hold_valid;
  assign a_load          = bus.a_res_valid & !a_hold_valid;
  assign m_load          = bus.m_res_valid & !m_hold_valid;
  assign out_idle        = !a_hold_valid & !m_hold_valid;

  result_hold_reg #(.PAYLOAD_W(PAYLOAD_W)) u_a_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (a_load),
    .clear (a_clear),
    .d     ({bus.a_result, bus.a_res_id}),
    .valid (a_hold_valid),
    .q     (a_payload)
  );

  result_hold_reg #(.PAYLOAD_W(PAYLOAD_W)) u_m_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (m_load),
    .clear (m_clear),
    .d     ({bus.m_result, bus.m_res_id}),
    .valid (m_hold_valid),
    .q     (m_payload)
  );

  // Grant, write enable and entry packing, all from registered state plus full_out.
  always_comb begin
    grant_mul = m_hold_valid & (!a_hold_valid | (last_grant == GRANT_ADD));
    w_en      = (a_hold_valid | m_hold_valid) & !bus.full_out;
    a_clear   = w_en & !grant_mul;
    m_clear   = w_en & grant_mul;
    entry     = '0;
    if (grant_mul) begin
      entry[OP_LSB  +: OPERATION_SIZE] = OPERATION_SIZE'(OP_MUL);
      entry[ID_LSB  +: ID_SIZE]        = m_payload[ID_SIZE-1:0];
      entry[RES_LSB +: DATA_SIZE]      = m_payload[PAYLOAD_W-1:ID_SIZE];
    end else if (a_hold_valid) begin
      entry[OP_LSB  +: OPERATION_SIZE] = OPERATION_SIZE'(OP_ADD);
      entry[ID_LSB  +: ID_SIZE]        = a_payload[ID_SIZE-1:0];
      entry[RES_LSB +: DATA_SIZE]      = a_payload[PAYLOAD_W-1:ID_SIZE];
    end
  end

  assign bus.w_en_out      = w_en;
  assign bus.fifo_out_data = entry;

  // Round-robin state and written-entry counter advance only on a FIFO write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_MUL;
      res_count  <= '0;
    end else if (w_en) begin
      last_grant <= grant_mul ? GRANT_MUL : GRANT_ADD;
      res_count  <= res_count + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_out_alu_control_unit.sv
// Scoreboard bench for out_alu_control_unit: directed scenarios followed by random traffic.
module tb_out_alu_control_unit;
  import out_alu_control_unit_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned IW = 8;
  localparam int unsigned OW = 2;
  localparam int unsigned CW = 16;
  localparam int unsigned EW = DW + IW + OW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  out_alu_control_unit_if #(.DATA_SIZE(DW), .ID_SIZE(IW), .OPERATION_SIZE(OW)) bus ();
  out_alu_control_unit_if #(.DATA_SIZE(DW), .ID_SIZE(IW), .OPERATION_SIZE(OW)) bus4 ();

  logic [CW-1:0] res_count;
  logic          out_idle;
  logic [3:0]    res_count4;
  logic          out_idle4;

  out_alu_control_unit #(.DATA_SIZE(DW), .ID_SIZE(IW), .OPERATION_SIZE(OW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .res_count (res_count),
    .out_idle  (out_idle)
  );

  // Narrow-counter copy sees identical traffic; only its wrapping counter is checked.
  out_alu_control_unit #(.DATA_SIZE(DW), .ID_SIZE(IW), .OPERATION_SIZE(OW), .CNT_WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus4),
    .res_count (res_count4),
    .out_idle  (out_idle4)
  );

  assign bus4.a_res_valid = bus.a_res_valid;
  assign bus4.a_result    = bus.a_result;
  assign bus4.a_res_id    = bus.a_res_id;
  assign bus4.m_res_valid = bus.m_res_valid;
  assign bus4.m_result    = bus.m_result;
  assign bus4.m_res_id    = bus.m_res_id;
  assign bus4.full_out    = bus.full_out;

  int tests = 0;
  int fails = 0;

  logic [EW-1:0] a_q[$];
  logic [EW-1:0] m_q[$];
  logic [EW-1:0] sb[$];
  bit            last_mul = 1'b1;
  int unsigned   cnt = 0;

  function automatic logic [EW-1:0] mk_entry(input logic [DW-1:0] r, input logic [IW-1:0] id,
                                             input logic [1:0] op);
    return {r, id, op};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel is a one-deep mailbox; the FIFO takes one entry per
  // non-full cycle, alternating between channels when both have something waiting.
  initial begin : model
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        a_q.delete(); m_q.delete(); sb.delete();
        last_mul = 1'b1;
        cnt      = 0;
        chk("rst_w_en",    64'(bus.w_en_out),      64'(0));
        chk("rst_a_ready", 64'(bus.a_res_ready),   64'(1));
        chk("rst_m_ready", 64'(bus.m_res_ready),   64'(1));
        chk("rst_data",    64'(bus.fifo_out_data), 64'(0));
        chk("rst_count",   64'(res_count),         64'(0));
        chk("rst_idle",    64'(out_idle),          64'(1));
      end else begin : live
        bit            any, pick_mul, exp_w, a_acc, m_acc;
        logic [EW-1:0] cand;
        any      = (a_q.size() != 0) || (m_q.size() != 0);
        pick_mul = (m_q.size() != 0) && ((a_q.size() == 0) || !last_mul);
        exp_w    = any && !bus.full_out;
        cand     = '0;
        if (pick_mul)              cand = m_q[0];
        else if (a_q.size() != 0)  cand = a_q[0];
        chk("a_ready",   64'(bus.a_res_ready),   64'(a_q.size() == 0));
        chk("m_ready",   64'(bus.m_res_ready),   64'(m_q.size() == 0));
        chk("w_en_out",  64'(bus.w_en_out),      64'(exp_w));
        chk("out_idle",  64'(out_idle),          64'(!any));
        chk("data",      64'(bus.fifo_out_data), 64'(cand));
        chk("res_count", 64'(res_count),         64'(cnt % 65536));
        chk("res_count4",64'(res_count4),        64'(cnt % 16));
        a_acc = bus.a_res_valid && (a_q.size() == 0);
        m_acc = bus.m_res_valid && (m_q.size() == 0);
        if (exp_w) begin
          if (pick_mul) sb.push_back(m_q.pop_front());
          else          sb.push_back(a_q.pop_front());
          last_mul = pick_mul;
          cnt++;
        end
        if (a_acc) a_q.push_back(mk_entry(bus.a_result, bus.a_res_id, OP_ADD));
        if (m_acc) m_q.push_back(mk_entry(bus.m_result, bus.m_res_id, OP_MUL));
      end
    end
  end

  // Monitor: every FIFO write must match the oldest expected entry.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.w_en_out) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got %0h expected no write at %0t", bus.fifo_out_data, $time);
        end else begin
          logic [EW-1:0] e;
          e = sb.pop_front();
          chk("fifo_entry", 64'(bus.fifo_out_data), 64'(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [DW-1:0] ad, input logic [IW-1:0] ai,
                       input logic mv, input logic [DW-1:0] md, input logic [IW-1:0] mi,
                       input logic full);
    bus.a_res_valid = av;
    bus.a_result    = ad;
    bus.a_res_id    = ai;
    bus.m_res_valid = mv;
    bus.m_result    = md;
    bus.m_res_id    = mi;
    bus.full_out    = full;
  endtask

  initial begin : stim
    bit acc;
    int waited;
    drive(0, '0, '0, 0, '0, '0, 0);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single add result.
    drive(1, 16'h1234, 8'h05, 0, '0, '0, 0);
    tick();
    drive(0, '0, '0, 0, '0, '0, 0);
    repeat (3) tick();
    chk("t1_count", 64'(res_count), 64'(1));

    // Same-cycle add and mul straight after reset: ADD goes first.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(1, 16'h0011, 8'h01, 1, 16'h00F0, 8'h02, 0);
    tick();
    drive(0, '0, '0, 0, '0, '0, 0);
    repeat (4) tick();

    // Both holds loaded while FIFO_OUT is full for five cycles.
    drive(1, 16'hAAAA, 8'h10, 1, 16'h5555, 8'h11, 1);
    tick();
    drive(0, '0, '0, 0, '0, '0, 1);
    repeat (5) tick();
    drive(0, '0, '0, 0, '0, '0, 0);
    repeat (4) tick();

    // Adder holds valid continuously; each id must be accepted exactly once, every other cycle.
    for (int k = 1; k <= 6; k++) begin
      drive(1, 16'(k * 257), 8'(k), 0, '0, '0, 0);
      waited = 0;
      acc    = 1'b0;
      do begin
        @(negedge clk);
        acc = bus.a_res_ready;
        waited++;
        tick();
      end while (!acc && waited < 10);
      chk("t4_accepted", 64'(acc), 64'(1));
      chk("t4_period", 64'(waited), 64'((k == 1) ? 1 : 2));
    end
    drive(0, '0, '0, 0, '0, '0, 0);
    repeat (3) tick();

    // Reset while the mul hold is full and FIFO_OUT blocks the write.
    drive(0, '0, '0, 1, 16'hBEEF, 8'h77, 1);
    tick();
    drive(0, '0, '0, 0, '0, '0, 1);
    tick();
    rst_n = 1'b0;
    tick();
    drive(0, '0, '0, 0, '0, '0, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Random traffic with random back-pressure.
    repeat (400) begin
      drive(($urandom_range(0, 9) < 6), DW'($urandom), IW'($urandom),
            ($urandom_range(0, 9) < 6), DW'($urandom), IW'($urandom),
            ($urandom_range(0, 3) == 0));
      tick();
    end
    drive(0, '0, '0, 0, '0, '0, 0);
    repeat (5) tick();
    chk("sb_drained", 64'(sb.size()), 64'(0));
    chk("final_idle", 64'(out_idle), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
